// File: rtl/coord_stack_pkg.sv
// coord_stack_pkg: shared widths, coordinate type and replay FSM states
package coord_stack_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_ADDR_H = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_PTR_W = 4;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] x;
    logic [DEF_ADDR_H-1:0] y;
  } coord_t;
  typedef enum logic {S_IDLE, S_REPLAY} state_t;
endpackage

// File: rtl/coord_stack_if.sv
// coord_stack_if: command, status and replay-stream signals of the coordinate stack
interface coord_stack_if #(
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4,
  parameter int PTR_W = 4
);
  logic clr;
  logic push;
  logic pop;
  logic [ADDR_W-1:0] push_x;
  logic [ADDR_H-1:0] push_y;
  logic [ADDR_W-1:0] top_x;
  logic [ADDR_H-1:0] top_y;
  logic empty;
  logic full;
  logic [PTR_W:0] count;
  logic ovf_err;
  logic udf_err;
  logic replay_start;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [ADDR_W-1:0] out_x;
  logic [ADDR_H-1:0] out_y;
  logic out_last;
  modport master (
    output clr, push, pop, push_x, push_y, replay_start, out_ready,
    input top_x, top_y, empty, full, count, ovf_err, udf_err, busy, out_valid, out_x, out_y, out_last
  );
  modport slave (
    input clr, push, pop, push_x, push_y, replay_start, out_ready,
    output top_x, top_y, empty, full, count, ovf_err, udf_err, busy, out_valid, out_x, out_y, out_last
  );
endinterface

// File: rtl/coord_mem.sv
// coord_mem: unreset storage array, one sync write port and two combinational read ports
module coord_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);
  logic [W-1:0] mem_q [DEPTH];
  // write port; contents survive reset and clear
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];
endmodule

// File: rtl/coord_stack.sv
// coord_stack: coordinate LIFO with full/empty, sticky errors and bottom-to-top replay
module coord_stack
  import coord_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ADDR_H = DEF_ADDR_H,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input logic clk,
  input logic rst,
  coord_stack_if.slave bus
);
  localparam int W = ADDR_W + ADDR_H;
  state_t state_q, state_d;
  logic [PTR_W:0] count_q, count_d, cnt_m1;
  logic [PTR_W-1:0] rd_idx_q, rd_idx_d, waddr;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic idle, empty, full, go, act, ps, po, pp, last, we;
  logic [W-1:0] top_d, rd_d;
  assign idle = state_q == S_IDLE;
  assign empty = count_q == '0;
  assign full = count_q == (PTR_W+1)'(DEPTH);
  assign cnt_m1 = count_q - 1'b1;
  assign last = {1'b0, rd_idx_q} == cnt_m1;
  assign ps = bus.push && !bus.pop;
  assign po = bus.pop && !bus.push;
  assign pp = bus.push && bus.pop;
  // a replay launch takes the cycle, so push/pop only act in an idle cycle without clr or launch
  assign go = idle && !bus.clr && bus.replay_start && !empty;
  assign act = idle && !bus.clr && !go;
  assign we = act && bus.push && (!full || (bus.pop && !empty));
  assign waddr = (bus.pop && !empty) ? cnt_m1[PTR_W-1:0] : count_q[PTR_W-1:0];
  coord_mem #(.W(W), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(waddr),
    .wdata({bus.push_x, bus.push_y}),
    .raddr_a(cnt_m1[PTR_W-1:0]),
    .rdata_a(top_d),
    .raddr_b(rd_idx_q),
    .rdata_b(rd_d)
  );
  // state, pointer and sticky flags; reset behaves like an asynchronous clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rd_idx_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_idx_q <= rd_idx_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  // next state: clr wins, then the replay FSM, then push/pop
  always_comb begin
    state_d = bus.clr ? S_IDLE : go ? S_REPLAY : (!idle && bus.out_ready && last) ? S_IDLE : state_q;
    rd_idx_d = idle ? '0 : bus.out_ready ? rd_idx_q + 1'b1 : rd_idx_q;
    count_d = bus.clr ? '0 :
              !act ? count_q :
              (ps && !full) || (pp && empty) ? count_q + 1'b1 :
              (po && !empty) ? cnt_m1 : count_q;
    ovf_d = !bus.clr && (ovf_q || (act && ps && full));
    udf_d = !bus.clr && (udf_q || (act && po && empty));
  end
  // outputs: replay stream is forced to zero outside REPLAY
  always_comb begin
    bus.busy = !idle;
    bus.out_valid = !idle;
    bus.out_last = !idle && last;
    {bus.out_x, bus.out_y} = idle ? '0 : rd_d;
    {bus.top_x, bus.top_y} = top_d;
    bus.empty = empty;
    bus.full = full;
    bus.count = count_q;
    bus.ovf_err = ovf_q;
    bus.udf_err = udf_q;
  end
endmodule

// File: tb/tb_coord_stack.sv
// tb_coord_stack: vector table, replay/clear/reset sequences and randomized model check
module tb_coord_stack;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  coord_stack_if #(.ADDR_W(4), .ADDR_H(4), .PTR_W(3)) bus ();
  coord_stack #(.ADDR_W(4), .ADDR_H(4), .DEPTH(DEPTH), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit c, p, o;
    int x, y, ec;
    bit ct;
    int tx, ty;
    bit eo, eu;
  } vec_t;
  vec_t vt[20];
  int q[$];
  bit m_ovf, m_udf, m_rep;
  int m_idx;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit c, bit p, bit o, int x, int y, bit rs, bit rdy);
    bus.clr = c;
    bus.push = p;
    bus.pop = o;
    bus.push_x = 4'(x);
    bus.push_y = 4'(y);
    bus.replay_start = rs;
    bus.out_ready = rdy;
  endtask

  task automatic chk_stat(string nm, int ec, bit eo, bit eu);
    chk({nm, " count"}, int'(bus.count), ec);
    chk({nm, " empty"}, int'(bus.empty), int'(ec == 0));
    chk({nm, " full"}, int'(bus.full), int'(ec == DEPTH));
    chk({nm, " ovf"}, int'(bus.ovf_err), int'(eo));
    chk({nm, " udf"}, int'(bus.udf_err), int'(eu));
  endtask

  task automatic chk_out(string nm, bit v, int x, int y, bit l);
    chk({nm, " busy"}, int'(bus.busy), int'(v));
    chk({nm, " valid"}, int'(bus.out_valid), int'(v));
    chk({nm, " out"}, int'({bus.out_x, bus.out_y}), x * 16 + y);
    chk({nm, " last"}, int'(bus.out_last), int'(l));
  endtask

  task automatic model(bit c, bit p, bit o, int d, bit rs, bit rdy);
    if (c) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      m_rep = 0;
    end else if (m_rep) begin
      if (rdy) begin
        if (m_idx == q.size() - 1) m_rep = 0;
        else m_idx++;
      end
    end else if (rs && q.size() > 0) begin
      m_rep = 1;
      m_idx = 0;
    end else if (p && o) begin
      if (q.size() == 0) q.push_back(d);
      else q[q.size()-1] = d;
    end else if (p) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) m_udf = 1;
      else void'(q.pop_back());
    end
  endtask

  initial begin
    vt[0]  = '{0, 1, 0, 1, 2, 1, 1, 1, 2, 0, 0};
    vt[1]  = '{0, 1, 0, 3, 4, 2, 1, 3, 4, 0, 0};
    vt[2]  = '{0, 1, 0, 5, 6, 3, 1, 5, 6, 0, 0};
    vt[3]  = '{0, 0, 1, 0, 0, 2, 1, 3, 4, 0, 0};
    vt[4]  = '{0, 0, 1, 0, 0, 1, 1, 1, 2, 0, 0};
    vt[5]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[7]  = '{0, 1, 1, 7, 7, 1, 1, 7, 7, 0, 1};
    vt[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    vt[10] = '{0, 1, 0, 2, 2, 2, 1, 2, 2, 0, 0};
    vt[11] = '{0, 1, 1, 9, 9, 2, 1, 9, 9, 0, 0};
    vt[12] = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    vt[13] = '{0, 1, 0, 2, 2, 2, 1, 2, 2, 0, 0};
    vt[14] = '{0, 1, 0, 3, 3, 3, 1, 3, 3, 0, 0};
    vt[15] = '{0, 1, 0, 4, 4, 4, 1, 4, 4, 0, 0};
    vt[16] = '{0, 1, 0, 5, 5, 4, 1, 4, 4, 1, 0};
    vt[17] = '{0, 1, 1, 6, 6, 4, 1, 6, 6, 1, 0};
    vt[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[19] = '{0, 1, 1, 8, 8, 1, 1, 8, 8, 0, 0};
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    chk_stat("reset", 0, 0, 0);
    chk_out("reset", 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].c, vt[i].p, vt[i].o, vt[i].x, vt[i].y, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_stat($sformatf("vec%0d", i), vt[i].ec, vt[i].eo, vt[i].eu);
      if (vt[i].ct) chk($sformatf("vec%0d top", i), int'({bus.top_x, bus.top_y}), vt[i].tx * 16 + vt[i].ty);
    end
    drive(1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 0, i, i, 0, 0); step();
    end
    drive(0, 0, 0, 0, 0, 1, 0); step();
    chk_out("rep b1", 1, 1, 1, 0);
    drive(0, 1, 0, 8, 8, 0, 0); step();
    chk_out("rep stall1", 1, 1, 1, 0);
    step();
    chk_out("rep stall2", 1, 1, 1, 0);
    chk_stat("rep push", 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk_out("rep b2", 1, 2, 2, 0);
    step();
    chk_out("rep b3", 1, 3, 3, 1);
    step();
    chk_out("rep done", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_stat("rep after", 3, 0, 0);
    chk("rep top", int'({bus.top_x, bus.top_y}), 3 * 16 + 3);
    drive(0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1); step();
    step();
    chk_out("clr pre", 1, 3, 3, 1);
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("clr mid", 0, 0, 0, 0);
    chk_stat("clr mid", 0, 0, 0);
    q.delete();
    m_ovf = 0; m_udf = 0; m_rep = 0; m_idx = 0;
    for (int n = 0; n < 600; n++) begin
      bit c, p, o, rs, rdy;
      int x, y;
      c = $urandom_range(0, 40) == 0;
      p = 1'($urandom);
      o = $urandom_range(0, 2) == 0;
      rs = $urandom_range(0, 9) == 0;
      rdy = 1'($urandom);
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      model(c, p, o, x * 16 + y, rs, rdy);
      drive(c, p, o, x, y, rs, rdy);
      step();
      chk_stat("rnd", q.size(), m_ovf, m_udf);
      if (q.size() > 0) chk("rnd top", int'({bus.top_x, bus.top_y}), q[q.size()-1]);
      if (m_rep) chk_out("rnd", 1, q[m_idx] / 16, q[m_idx] % 16, m_idx == q.size() - 1);
      else chk_out("rnd", 0, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0, 0, 0); step();
    drive(0, 1, 0, 1, 1, 0, 0); step();
    drive(0, 1, 0, 2, 2, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); step();
    chk_stat("arst pre", 2, 0, 1);
    chk_out("arst pre", 1, 1, 1, 0);
    drive(0, 1, 0, 3, 3, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_stat("arst", 0, 0, 0);
    chk_out("arst", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk_stat("arst post", 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
